// File: rtl/adder_test_pkg.sv
// adder_test_pkg: shared state encoding, error-counter limits and vector-count helper
package adder_test_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam int ERR_W = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  function automatic int num_vec(input int width);
    return 1 << (2 * width + 1);
  endfunction
endpackage

// File: rtl/adder_golden_ref.sv
// adder_golden_ref: combinational reference sum {cout,s} = a + b + cin
module adder_golden_ref #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: exhaustive A/B/Cin sweep of an external adder with mismatch count and first-fail capture
module adder_sweep_checker
  import adder_test_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_s,
  output logic             fail_cout
);
  localparam int VW = 2 * WIDTH + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [VW-1:0] VEC_LAST = VW'(num_vec(WIDTH) - 1);
  state_t state, state_d;
  logic [VW-1:0] vec;
  logic [SW-1:0] settle_cnt;
  logic [WIDTH:0] expected;
  logic mismatch, last;
  // the vector counter is {cin,a,b}, so a plain increment gives b innermost and cin outermost
  assign dut_cin  = vec[VW-1];
  assign dut_a    = vec[2*WIDTH-1:WIDTH];
  assign dut_b    = vec[WIDTH-1:0];
  assign last     = vec == VEC_LAST;
  assign mismatch = {dut_cout, dut_s} != expected;
  assign busy     = state == APPLY || state == CHECK;
  assign done     = state == DONE;
  assign pass     = done && err_count == '0;
  adder_golden_ref #(.WIDTH(WIDTH)) u_ref (
    .a  (dut_a),
    .b  (dut_b),
    .cin(dut_cin),
    .sum(expected)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  // next state: start honoured only when idle or done, otherwise settle then check each vector
  always_comb begin
    state_d = state;
    state_d = (state == IDLE || state == DONE) ? (start ? APPLY : state) :
              (state == APPLY) ? (settle_cnt == SETTLE_LAST ? CHECK : APPLY) :
              (last ? DONE : APPLY);
  end
  // vector, settle counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_s     <= '0;
      fail_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          vec        <= '0;
          settle_cnt <= '0;
          err_count  <= '0;
          fail_valid <= 1'b0;
          fail_a     <= '0;
          fail_b     <= '0;
          fail_cin   <= 1'b0;
          fail_s     <= '0;
          fail_cout  <= 1'b0;
        end
        APPLY: settle_cnt <= settle_cnt + 1'b1;
        CHECK: begin
          if (mismatch && err_count != ERR_MAX) err_count <= err_count + 1'b1;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= dut_a;
            fail_b     <= dut_b;
            fail_cin   <= dut_cin;
            fail_s     <= dut_s;
            fail_cout  <= dut_cout;
          end
          if (!last) begin
            vec        <= vec + 1'b1;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
